// File: rtl/mem_bridge_pkg.sv
// Shared types and default widths for the memory request bridge and its request FIFO.
package mem_bridge_pkg;

  localparam int unsigned MEM_ADDR_W = 32;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_DEPTH  = 4;
  localparam int unsigned MEM_RD_LAT = 2;

  typedef struct packed {
    logic                  write;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    RESP
  } bridge_state_e;

endpackage

// File: rtl/mem_req_fifo.sv
// DEPTH-entry synchronous FIFO of mem_req_t; pointers carry an extra wrap bit to tell
// full from empty.
module mem_req_fifo
  import mem_bridge_pkg::*;
#(
  parameter int unsigned DEPTH = MEM_DEPTH
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     push,
  input  mem_req_t push_data,
  input  logic     pop,
  output mem_req_t head,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  mem_req_t    mem_q [DEPTH];
  logic        do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/mem_req_bridge.sv
// Request FIFO plus issue FSM driving single-cycle memory strobes and returning read data.
// Define MEM_REQ_BRIDGE_SVA_EN to compile embedded assertions and covers.
module mem_req_bridge
  import mem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W,
  parameter int unsigned DEPTH  = MEM_DEPTH,
  parameter int unsigned RD_LAT = MEM_RD_LAT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              write,
  output logic              read,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata
);

  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  bridge_state_e     state_q, state_d;
  logic              write_q, write_d, read_q, read_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  mem_req_t push_req, head;
  logic     fifo_pop, fifo_full, fifo_empty, issue;

  assign push_req.write = req_write;
  assign push_req.addr  = MEM_ADDR_W'(req_addr);
  assign push_req.wdata = MEM_DATA_W'(req_wdata);
  assign req_ready      = !fifo_full;

  mem_req_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (req_valid && req_ready),
    .push_data(push_req),
    .pop      (fifo_pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    write_d     = 1'b0;
    read_d      = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lat_d       = lat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    fifo_pop    = 1'b0;
    issue       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          issue   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (read_q) begin
          // With a one-cycle latency the sample edge is the one leaving ISSUE.
          if (RD_LAT == 1) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rdata;
            state_d     = RESP;
          end else begin
            lat_d   = LAT_W'(RD_LAT - 1);
            state_d = WAIT_RD;
          end
        end else if (!fifo_empty) begin
          issue = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_RD: begin
        if (lat_q == LAT_W'(1)) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rdata;
          state_d     = RESP;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      fifo_pop = 1'b1;
      write_d  = head.write;
      read_d   = !head.write;
      addr_d   = ADDR_W'(head.addr);
      if (head.write) wdata_d = DATA_W'(head.wdata);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      read_q      <= read_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_q       <= lat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign write     = write_q;
  assign read      = read_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef MEM_REQ_BRIDGE_SVA_EN
  default clocking sva_cb @(posedge clk); endclocking
  default disable iff (!reset_n);

  a_no_both:      assert property (!(write && read));
  c_no_both:      cover property (write ##1 read);
  // Back-to-back writes legitimately keep write high; each one pops a new entry.
  a_write_pulse:  assert property (write && !fifo_pop |=> !write);
  c_write_pulse:  cover property (write && !fifo_pop ##1 !write);
  a_read_pulse:   assert property (read |=> !read);
  c_read_pulse:   cover property (read ##1 !read);
  a_rsp_hold:     assert property (rsp_valid && !rsp_ready |=> $stable(rsp_rdata) && rsp_valid);
  c_rsp_hold:     cover property (rsp_valid && !rsp_ready ##1 rsp_valid);
  a_req_hold:     assert property (req_valid && !req_ready |=> req_valid);
  c_req_hold:     cover property (req_valid && !req_ready ##1 req_valid);
  a_no_push_full: assert property (!(req_valid && req_ready && fifo_full));
  c_no_push_full: cover property (req_valid && fifo_full);
`endif

endmodule

// File: tb/tb_mem_req_bridge.sv
// Directed bench for mem_req_bridge with a small memory model and strobe/response logs.
module tb_mem_req_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          write, read;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata = '0;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;

  mem_req_bridge #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .DEPTH (4),
    .RD_LAT(2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .write    (write),
    .read     (read),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: read data appears one edge after the strobe and holds.
  logic [DW-1:0] tbmem [256];
  always @(posedge clk) begin
    if (write) tbmem[addr[7:0]] <= wdata;
    if (read)  rdata <= tbmem[addr[7:0]];
  end

  typedef struct {
    int          cyc;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } strobe_t;

  strobe_t     log_q[$];
  logic [31:0] rsp_q[$];
  int          cyc = 0;
  int          both_cnt = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if (write && read) both_cnt++;
      if (write || read) log_q.push_back('{cyc, write, addr, wdata});
      if (rsp_valid && rsp_ready) rsp_q.push_back(rsp_rdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called just after a posedge; returns just after the accepting edge.
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input bit keep);
    bit done;
    done      = 1'b0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    for (int i = 0; i < 60 && !done; i++) begin
      if (req_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!keep) req_valid = 1'b0;
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int marker;
    int rmark;
    int c_h;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_write", write, 0);
    check("rst_read", read, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    @(posedge clk);
    #1;

    // 1: single write, strobe one cycle after the accept edge
    send(1'b1, 32'h10, 32'hA5A5_0001, 1'b0);
    @(negedge clk);
    check("t1_write_early", write, 0);
    @(negedge clk);
    check("t1_write", write, 1);
    check("t1_read", read, 0);
    check("t1_addr", addr, 32'h10);
    check("t1_wdata", wdata, 32'hA5A5_0001);
    @(negedge clk);
    check("t1_write_off", write, 0);
    check("t1_no_rsp", rsp_valid, 0);
    check("t1_rsp_log", rsp_q.size(), 0);
    @(posedge clk);
    #1;

    // 2: read back, rsp_valid at T+1+RD_LAT
    send(1'b0, 32'h10, 32'h0, 1'b0);
    @(negedge clk);
    check("t2_read_early", read, 0);
    @(negedge clk);
    check("t2_read", read, 1);
    check("t2_addr", addr, 32'h10);
    check("t2_wdata_kept", wdata, 32'hA5A5_0001);
    @(negedge clk);
    check("t2_rsp_early", rsp_valid, 0);
    @(negedge clk);
    check("t2_rsp_valid", rsp_valid, 1);
    check("t2_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t2_rsp_clear", rsp_valid, 0);
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;

    // 3: response blocks the FSM, six writes fill the FIFO then drain 1/cycle
    marker = log_q.size();
    send(1'b0, 32'h10, 32'h0, 1'b0);
    fork
      begin
        for (int i = 0; i < 6; i++) send(1'b1, 32'h40 + i, 32'h300 + i, 1'b1);
        req_valid = 1'b0;
      end
      begin
        step(12);
        check("t3_full_ready", req_ready, 0);
        check("t3_no_wr_yet", log_q.size() - marker, 1);
        rsp_ready = 1'b1;
      end
    join
    step(15);
    check("t3_strobe_cnt", log_q.size() - marker, 7);
    if (log_q.size() - marker == 7) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("t3_w%0d_kind", i), log_q[marker+1+i].w, 1);
        check($sformatf("t3_w%0d_addr", i), log_q[marker+1+i].a, 32'h40 + i);
        check($sformatf("t3_w%0d_data", i), log_q[marker+1+i].d, 32'h300 + i);
        check($sformatf("t3_w%0d_cyc", i), log_q[marker+1+i].cyc - log_q[marker+1].cyc, i);
      end
    end
    check("t3_rsp", rsp_q[rsp_q.size()-1], 32'hA5A5_0001);
    rsp_ready = 1'b0;

    // 4: held response with a queued write behind it
    marker = log_q.size();
    send(1'b0, 32'h41, 32'h0, 1'b0);
    send(1'b1, 32'h50, 32'h55, 1'b0);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    check("t4_rsp_valid", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t4_hold%0d_valid", i), rsp_valid, 1);
      check($sformatf("t4_hold%0d_data", i), rsp_rdata, 32'h301);
      check($sformatf("t4_hold%0d_nowr", i), write, 0);
    end
    c_h = cyc;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("t4_rsp_clear", rsp_valid, 0);
    rsp_ready = 1'b0;
    step(5);
    check("t4_strobe_cnt", log_q.size() - marker, 2);
    if (log_q.size() - marker == 2) begin
      check("t4_wr_kind", log_q[marker+1].w, 1);
      check("t4_wr_addr", log_q[marker+1].a, 32'h50);
      check("t4_wr_after_hs", log_q[marker+1].cyc > c_h, 1);
    end

    // 5: reset during WAIT_RD
    marker = log_q.size();
    rmark  = rsp_q.size();
    send(1'b0, 32'h10, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("t5_read", read, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t5_write", write, 0);
    check("t5_read_off", read, 0);
    check("t5_addr", addr, 0);
    check("t5_wdata", wdata, 0);
    check("t5_rsp_valid", rsp_valid, 0);
    check("t5_rsp_rdata", rsp_rdata, 0);
    step(2);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("t5_no_rsp%0d", i), rsp_valid, 0);
    end
    check("t5_req_ready", req_ready, 1);
    check("t5_no_strobe", log_q.size() - marker, 1);
    check("t5_rsp_log", rsp_q.size() - rmark, 0);
    @(posedge clk);
    #1;

    // 6: interleaved writes and reads to one address
    rsp_ready = 1'b1;
    rmark = rsp_q.size();
    send(1'b1, 32'h4, 32'd7, 1'b0);
    send(1'b0, 32'h4, 32'h0, 1'b0);
    send(1'b1, 32'h4, 32'd9, 1'b0);
    send(1'b0, 32'h4, 32'h0, 1'b0);
    for (int i = 0; i < 60 && rsp_q.size() < rmark + 2; i++) @(negedge clk);
    check("t6_rsp_cnt", rsp_q.size() - rmark, 2);
    if (rsp_q.size() - rmark == 2) begin
      check("t6_rsp0", rsp_q[rmark], 32'd7);
      check("t6_rsp1", rsp_q[rmark+1], 32'd9);
    end
    check("no_both_strobes", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
